// File: rtl/occupancy_dump_pkg.sv
// Shared types and constants for the occupancy map dumper.
//   dump_state_t    : sequencing states of the dump FSM
//   SYNC_BYTE_0/1   : two-byte header sent ahead of the cell bytes
//   UART_FRAME_BITS : start + 8 data + stop
//   HDR_*           : header progress codes held in the top-level hdr_idx register
package occupancy_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_WAIT_DATA,
        ST_SEND,
        ST_WAIT_TX,
        ST_FINISH
    } dump_state_t;

    localparam logic [7:0] SYNC_BYTE_0     = 8'hA5;
    localparam logic [7:0] SYNC_BYTE_1     = 8'h5A;
    localparam int         UART_FRAME_BITS = 10;

    // Header progress: which sync byte is next, and when the header is over.
    localparam logic [1:0] HDR_SEND_0 = 2'd0;  // 0xA5 not yet loaded
    localparam logic [1:0] HDR_SEND_1 = 2'd1;  // 0xA5 sent, 0x5A pending
    localparam logic [1:0] HDR_LAST   = 2'd2;  // 0x5A loaded / on the line
    localparam logic [1:0] HDR_DONE   = 2'd3;  // header complete, cells follow

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low; forces the line idle (high)
//   tx_start : one-cycle request, accepted only while idle
//   tx_data  : byte to send, sampled with tx_start
//   tx_busy  : high from acceptance until the stop bit has been held its full period
//   tx       : serial line, idle high
module uart_tx
    import occupancy_dump_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    localparam int                BAUD_W    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_STOP  = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]        BIT_LAST_DATA = 4'(UART_FRAME_BITS - 2);

    logic [BAUD_W-1:0] baud_q;
    logic [3:0]        bit_q;
    logic [7:0]        shift_q;
    logic              busy_q;
    logic              tx_q;

    logic bit_end;
    assign bit_end = busy_q && (baud_q == BAUD_LAST);

    // bit_q counts frame positions: 0 = start, 1..8 = data, 9 = stop.
    // The line level for the next position is registered at the end of the current one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            baud_q <= '0;
            bit_q  <= '0;
        end else if (!busy_q) begin
            if (tx_start) begin
                busy_q <= 1'b1;
                tx_q   <= 1'b0;
                baud_q <= '0;
                bit_q  <= '0;
            end
        end else if (bit_end) begin
            baud_q <= '0;
            if (bit_q == BIT_STOP) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                bit_q <= bit_q + 4'd1;
                tx_q  <= (bit_q == BIT_LAST_DATA) ? 1'b1 : shift_q[0];
            end
        end else begin
            baud_q <= baud_q + BAUD_W'(1);
        end
    end

    // Data path carries no reset; it is always reloaded before use.
    always_ff @(posedge clock) begin
        if (!busy_q && tx_start) begin
            shift_q <= tx_data;
        end else if (bit_end && (bit_q < BIT_LAST_DATA)) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

    assign tx_busy = busy_q;
    assign tx      = tx_q;

endmodule

// File: rtl/occupancy_map_dumper.sv
// Occupancy grid readout: on start, sends sync bytes 0xA5 0x5A and then every
// memory cell 0..DEPTH-1 as 8N1 UART bytes.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low
//   start    : one-cycle dump request, honoured only while idle
//   mem_addr : occupancy memory read address (holds its value outside reads)
//   mem_data : read data, valid one cycle after mem_addr
//   busy     : dump in progress (drops in the cycle done pulses)
//   done     : one-cycle pulse after the final stop bit
//   tx       : UART line, idle high
module occupancy_map_dumper
    import occupancy_dump_pkg::*;
#(
    parameter int DEPTH          = 32768,
    parameter int ADDR_WIDTH     = 15,
    parameter int CELL_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [CELL_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  tx
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [7:0]            byte_q, byte_d;
    logic                  tx_start;
    logic                  tx_busy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            hdr_idx_q  <= HDR_SEND_0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            hdr_idx_q  <= hdr_idx_d;
        end
    end

    always_ff @(posedge clock) begin
        byte_q <= byte_d;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        hdr_idx_d  = hdr_idx_q;
        byte_d     = byte_q;
        mem_addr   = mem_addr_q;
        tx_start   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    addr_d    = '0;
                    hdr_idx_d = HDR_SEND_0;
                    state_d   = ST_HEADER;
                end
            end
            ST_HEADER: begin
                // The second sync byte spends one extra cycle here so that its
                // byte period matches the three-cycle lead-in of a cell read.
                case (hdr_idx_q)
                    HDR_SEND_0: begin
                        byte_d    = SYNC_BYTE_0;
                        hdr_idx_d = HDR_SEND_1;
                        state_d   = ST_SEND;
                    end
                    HDR_SEND_1: begin
                        byte_d    = SYNC_BYTE_1;
                        hdr_idx_d = HDR_LAST;
                    end
                    default: state_d = ST_SEND;
                endcase
            end
            ST_READ: begin
                // Address goes out combinationally so the 1-cycle memory
                // returns data during WAIT_DATA.
                mem_addr   = addr_q;
                mem_addr_d = addr_q;
                state_d    = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                byte_d  = mem_data[7:0];
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_start = 1'b1;
                state_d  = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!tx_busy) begin
                    if (hdr_idx_q == HDR_SEND_1) begin
                        state_d = ST_HEADER;
                    end else if (hdr_idx_q == HDR_LAST) begin
                        hdr_idx_d = HDR_DONE;
                        state_d   = ST_READ;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = ST_FINISH;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_tx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_uart_tx (
        .clock   (clock),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (byte_q),
        .tx_busy (tx_busy),
        .tx      (tx)
    );

endmodule

// File: tb/tb_occupancy_map_dumper.sv
module tb_occupancy_map_dumper;

    localparam int CPB    = 4;
    localparam int FRAME  = 10 * CPB;
    localparam int PERIOD = FRAME + 4;
    localparam int AW     = 15;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          start_a, start_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [7:0]    mem_data_a, mem_data_b;
    logic          busy_a, done_a, tx_a;
    logic          busy_b, done_b, tx_b;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b0;

    occupancy_map_dumper #(
        .DEPTH(4), .ADDR_WIDTH(AW), .CELL_WIDTH(8), .CLOCKS_PER_BIT(CPB)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .busy(busy_a), .done(done_a), .tx(tx_a)
    );

    occupancy_map_dumper #(
        .DEPTH(1), .ADDR_WIDTH(AW), .CELL_WIDTH(8), .CLOCKS_PER_BIT(CPB)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .busy(busy_b), .done(done_b), .tx(tx_b)
    );

    // 1-cycle-latency memories; out-of-range reads return a marker value.
    always @(posedge clock) begin
        mem_data_a <= (mem_addr_a < AW'(4)) ? mem_a[mem_addr_a[1:0]] : 8'hEE;
        mem_data_b <= (mem_addr_b == '0) ? mem_b0 : 8'hEE;
    end

    int checks = 0;
    int failures = 0;

    bit         s_tx[$];
    bit         s_busy[$];
    bit         s_done[$];
    int         s_addr[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         plan[512];

    task automatic clear_plan();
        for (int i = 0; i < 512; i++) plan[i] = 1'b0;
    endtask

    task automatic set_exp_a();
        exp_q = '{8'hA5, 8'h5A};
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_a[k]);
    endtask

    // Pulses start (edge N); sample i is taken after edge N+i. plan[i] is the
    // start level driven into edge N+i+1.
    task automatic capture(input bit sel, input int n);
        s_tx.delete(); s_busy.delete(); s_done.delete(); s_addr.delete();
        @(negedge clock);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                s_tx.push_back(tx_b); s_busy.push_back(busy_b);
                s_done.push_back(done_b); s_addr.push_back(int'(mem_addr_b));
                start_b = plan[i];
            end else begin
                s_tx.push_back(tx_a); s_busy.push_back(busy_a);
                s_done.push_back(done_a); s_addr.push_back(int'(mem_addr_a));
                start_a = plan[i];
            end
            @(negedge clock);
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Reference line level: byte k's frame begins 2 cycles after start plus k byte periods.
    function automatic bit model_tx(int i);
        int base;
        int j;
        for (int k = 0; k < exp_q.size(); k++) begin
            base = 2 + PERIOD * k;
            if (i >= base && i < base + FRAME) begin
                j = (i - base) / CPB;
                if (j == 0) return 1'b0;
                if (j == 9) return 1'b1;
                return exp_q[k][j-1];
            end
        end
        return 1'b1;
    endfunction

    // Independent mid-bit UART receiver over the captured line samples.
    function automatic void decode(int limit);
        int i;
        logic [7:0] b;
        got_q.delete();
        i = 1;
        while (i < limit && i + FRAME <= s_tx.size()) begin
            if (s_tx[i-1] == 1'b1 && s_tx[i] == 1'b0 && i + FRAME <= limit) begin
                for (int j = 0; j < 8; j++) b[j] = s_tx[i + CPB/2 + CPB*(j+1)];
                got_q.push_back(b);
                i = i + FRAME;
            end else begin
                i = i + 1;
            end
        end
    endfunction

    function automatic int first_done(int limit);
        for (int i = 0; i < limit && i < s_done.size(); i++) if (s_done[i]) return i;
        return -1;
    endfunction

    function automatic int count_done(int limit);
        int n = 0;
        for (int i = 0; i < limit && i < s_done.size(); i++) if (s_done[i]) n++;
        return n;
    endfunction

    function automatic int busy_bad(int d, int limit);
        if (d < 0) return 0;
        for (int i = 0; i < limit && i < s_busy.size(); i++)
            if (s_busy[i] != (i < d)) return i;
        return -1;
    endfunction

    function automatic int wave_bad(int limit);
        for (int i = 0; i < limit && i < s_tx.size(); i++)
            if (s_tx[i] != model_tx(i)) return i;
        return -1;
    endfunction

    function automatic int timing_bad(int limit);
        int f = -1;
        for (int i = 1; i < limit && i < s_tx.size(); i++) begin
            if (s_tx[i] != s_tx[i-1]) begin
                if (f < 0) f = i;
                else if (((i - f) % CPB) != 0) return i;
            end
        end
        return -1;
    endfunction

    function automatic int max_addr(int limit);
        int m = 0;
        for (int i = 0; i < limit && i < s_addr.size(); i++) if (s_addr[i] > m) m = s_addr[i];
        return m;
    endfunction

    task automatic test_reset();
        int n_tx = 0, n_busy = 0, n_done = 0, n_addr = 0;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        reset = 1'b1; start_a = 1'b0;
        @(negedge clock);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL reset_beats_start: busy=%0b expected 0", busy_a);
        end
        for (int i = 0; i < 100; i++) begin
            if (tx_a !== 1'b1 || tx_b !== 1'b1) n_tx++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) n_busy++;
            if (done_a !== 1'b0 || done_b !== 1'b0) n_done++;
            if (mem_addr_a !== '0 || mem_addr_b !== '0) n_addr++;
            @(negedge clock);
        end
        checks++; if (n_tx != 0) begin failures++; $display("FAIL idle_tx: %0d bad cycles, expected 0", n_tx); end
        checks++; if (n_busy != 0) begin failures++; $display("FAIL idle_busy: %0d bad cycles, expected 0", n_busy); end
        checks++; if (n_done != 0) begin failures++; $display("FAIL idle_done: %0d bad cycles, expected 0", n_done); end
        checks++; if (n_addr != 0) begin failures++; $display("FAIL idle_addr: %0d bad cycles, expected 0", n_addr); end
    endtask

    task automatic test_dump_fixed();
        int d;
        mem_a[0] = 8'h00; mem_a[1] = 8'hFF; mem_a[2] = 8'h3C; mem_a[3] = 8'h81;
        set_exp_a();
        clear_plan();
        capture(1'b0, 300);
        decode(300);
        checks++;
        if (got_q.size() != 6) begin
            failures++; $display("FAIL dump_byte_count: got %0d expected 6", got_q.size());
        end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL dump_byte%0d: got %02h expected %02h", k, got_q[k], exp_q[k]);
            end
        end
        d = first_done(300);
        checks++;
        if (count_done(300) != 1) begin
            failures++; $display("FAIL dump_done_count: got %0d expected 1", count_done(300));
        end
        checks++;
        if (d < 6*PERIOD - 2 || d > 6*PERIOD + 2) begin
            failures++; $display("FAIL dump_done_time: got %0d expected %0d+-2", d, 6*PERIOD);
        end
        checks++;
        if (busy_bad(d, 300) != -1) begin
            failures++; $display("FAIL dump_busy_window: first bad cycle %0d expected none", busy_bad(d, 300));
        end
        checks++;
        if (max_addr(300) > 3) begin
            failures++; $display("FAIL dump_addr_range: max %0d expected <=3", max_addr(300));
        end
    endtask

    task automatic test_bit_timing();
        int d;
        for (int k = 0; k < 4; k++) mem_a[k] = 8'($urandom);
        set_exp_a();
        clear_plan();
        repeat ($urandom_range(1, 20)) @(negedge clock);
        capture(1'b0, 300);
        d = first_done(300);
        decode(300);
        checks++;
        if (got_q.size() != 6) begin
            failures++; $display("FAIL rand_byte_count: got %0d expected 6", got_q.size());
        end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL rand_byte%0d: got %02h expected %02h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (wave_bad(300) != -1) begin
            failures++; $display("FAIL rand_waveform: first bad cycle %0d got %0b expected %0b",
                                 wave_bad(300), s_tx[wave_bad(300)], model_tx(wave_bad(300)));
        end
        checks++;
        if (timing_bad(300) != -1) begin
            failures++; $display("FAIL bit_boundary: edge at cycle %0d off the %0d-cycle grid", timing_bad(300), CPB);
        end
        checks++;
        if (d < 6*PERIOD - 2 || d > 6*PERIOD + 2) begin
            failures++; $display("FAIL rand_done_time: got %0d expected %0d+-2", d, 6*PERIOD);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n_done = 0, n_tx = 0;
        set_exp_a();
        clear_plan();
        capture(1'b0, 2 + 2*PERIOD + 12);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (tx_a !== 1'b1) begin failures++; $display("FAIL abort_tx: got %0b expected 1", tx_a); end
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b expected 0", busy_a); end
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (done_a !== 1'b0) n_done++;
            if (tx_a !== 1'b1) n_tx++;
            @(negedge clock);
        end
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL abort_no_done: %0d pulses expected 0", n_done); end
        checks++;
        if (n_tx != 0) begin failures++; $display("FAIL abort_line_idle: %0d low cycles expected 0", n_tx); end
        capture(1'b0, 300);
        decode(300);
        checks++;
        if (got_q.size() != 6) begin
            failures++; $display("FAIL redump_byte_count: got %0d expected 6", got_q.size());
        end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL redump_byte%0d: got %02h expected %02h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (count_done(300) != 1) begin
            failures++; $display("FAIL redump_done_count: got %0d expected 1", count_done(300));
        end
    endtask

    task automatic test_start_held();
        int d;
        bit seen;
        set_exp_a();
        clear_plan();
        for (int k = 0; k < 8; k++) plan[$urandom_range(5, 250)] = 1'b1;
        for (int i = 255; i <= 275; i++) plan[i] = 1'b1;
        capture(1'b0, 320);
        d = first_done(320);
        checks++;
        if (d < 6*PERIOD - 2 || d > 6*PERIOD + 2) begin
            failures++; $display("FAIL held_done_time: got %0d expected %0d+-2", d, 6*PERIOD);
        end
        if (d < 0) d = 6*PERIOD;
        decode(d + 1);
        checks++;
        if (got_q.size() != 6) begin
            failures++; $display("FAIL held_byte_count: got %0d expected 6", got_q.size());
        end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL held_byte%0d: got %02h expected %02h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (wave_bad(d + 1) != -1) begin
            failures++; $display("FAIL held_waveform: first bad cycle %0d", wave_bad(d + 1));
        end
        checks++;
        if (busy_bad(d, d + 1) != -1) begin
            failures++; $display("FAIL held_busy_window: first bad cycle %0d", busy_bad(d, d + 1));
        end
        checks++;
        if (s_busy[d+2] !== 1'b1) begin
            failures++; $display("FAIL restart_busy: got %0b expected 1", s_busy[d+2]);
        end
        checks++;
        if (s_tx[d+3] !== 1'b1 || s_tx[d+4] !== 1'b0) begin
            failures++; $display("FAIL restart_start_bit: got %0b%0b expected 10", s_tx[d+3], s_tx[d+4]);
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done_a === 1'b1) seen = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL restart_done: no done within 400 cycles, expected one"); end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_depth_one();
        int d;
        mem_b0 = 8'h00;
        exp_q = '{8'hA5, 8'h5A, 8'h00};
        clear_plan();
        capture(1'b1, 200);
        decode(200);
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL d1_byte_count: got %0d expected 3", got_q.size());
        end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL d1_byte%0d: got %02h expected %02h", k, got_q[k], exp_q[k]);
            end
        end
        d = first_done(200);
        checks++;
        if (count_done(200) != 1) begin
            failures++; $display("FAIL d1_done_count: got %0d expected 1", count_done(200));
        end
        checks++;
        if (d < 3*PERIOD - 2 || d > 3*PERIOD + 2) begin
            failures++; $display("FAIL d1_done_time: got %0d expected %0d+-2", d, 3*PERIOD);
        end
        checks++;
        if (max_addr(200) != 0) begin
            failures++; $display("FAIL d1_addr: max %0d expected 0", max_addr(200));
        end
        checks++;
        if (busy_bad(d, 200) != -1) begin
            failures++; $display("FAIL d1_busy_window: first bad cycle %0d", busy_bad(d, 200));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_b0 = 8'h00;
        for (int k = 0; k < 4; k++) mem_a[k] = 8'h00;
        test_reset();
        test_dump_fixed();
        test_bit_timing();
        test_reset_mid_dump();
        test_start_held();
        test_depth_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/occupancy_map_dumper.md
# occupancy_map_dumper

Downstream readout stage for the occupancy grid produced by `hector_slam_fpga`. On a start pulse it walks the occupancy memory sequentially through its read port and serialises every cell as one 8N1 UART byte, preceded by a two-byte sync header. The grid can then be captured on a host without the simulator hierarchy dump. It sits beside the occupancy module and shares its memory read port; the top-level arbitrates that port via `busy`.

## Interface

Parameters:
- `DEPTH`, 32768: number of cells to dump (256×128 grid).
- `ADDR_WIDTH`, 15: memory address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- `CELL_WIDTH`, 8: occupancy cell width. Fixed at 8 (one byte per cell).
- `CLOCKS_PER_BIT`, 868: UART bit period in clock cycles (100 MHz / 115200).

Ports (one clock; reset is synchronous and active-low):
- `clock` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-low; `reset==0` sampled at a rising edge resets the block.
- `start` input 1: one-cycle request to begin a dump.
- `mem_addr` output ADDR_WIDTH: read address into the occupancy memory.
- `mem_data` input CELL_WIDTH: read data, valid exactly 1 cycle after `mem_addr` is presented.
- `busy` output 1: high from start acceptance until the last stop bit ends.
- `done` output 1: one-cycle pulse after the final stop bit.
- `tx` output 1: UART serial line, idle high.

## Operation

- FSM states: IDLE, HEADER, READ, WAIT_DATA, SEND, WAIT_TX, FINISH.
- IDLE:
  - `tx=1`, `busy=0`.
  - `start==1` → load `addr=0`, `hdr_idx=0` → HEADER.
  - `start` is ignored in every other state.
- HEADER:
  - Hand byte 0xA5, then 0x5A, to the transmitter; wait in WAIT_TX after each byte.
  - After 0x5A completes → READ.
- READ: drive `mem_addr=addr` → WAIT_DATA.
- WAIT_DATA: latch `mem_data` into the byte register → SEND.
- SEND: assert one-cycle `tx_start` to the transmitter → WAIT_TX.
- WAIT_TX, when the transmitter reports idle:
  - if still in the header → back to HEADER;
  - else if `addr==DEPTH-1` → FINISH;
  - else `addr+1` → READ.
- FINISH: pulse `done` for 1 cycle → IDLE.
- Address counter:
  - ADDR_WIDTH bits; it never wraps, because termination is by comparison with DEPTH-1.
  - DEPTH=1 is legal: header followed by one cell.
- UART framing:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly CLOCKS_PER_BIT cycles.
- `mem_addr` holds its last value outside READ; it is 0 after reset.

## Timing

- Reset values: `tx=1`, `busy=0`, `done=0`, `mem_addr=0`; FSM in IDLE; transmitter idle.
- Reset mid-dump:
  - Abort immediately.
  - `tx` returns high in the same cycle as the reset edge; a truncated frame is acceptable.
  - No `done` pulse is issued.
- Start latency:
  - `start` high at edge N → `busy=1` after edge N.
  - `tx` falls (header start bit) after edge N+2.
- Per-cell overhead: READ + WAIT_DATA + SEND = 3 cycles, plus 10·CLOCKS_PER_BIT for the frame, plus 1 cycle to detect idle.
- Byte period: 10·CLOCKS_PER_BIT + 4 cycles. Total dump ≈ (DEPTH+2)·(10·CLOCKS_PER_BIT+4) cycles.
- `busy` falls in the same cycle `done` pulses.
- `start` coincident with `reset==0`: reset wins.
- `start` held high for several cycles: exactly one dump runs; after `done`, a still-high `start` begins a new dump.

## Structure

- Package `occupancy_dump_pkg`:
  - `dump_state_t` enum;
  - constants `SYNC_BYTE_0=8'hA5`, `SYNC_BYTE_1=8'h5A`, `UART_FRAME_BITS=10`.
- Sub-module `uart_tx`:
  - parameter CLOCKS_PER_BIT;
  - ports `clock`, `reset`, `tx_start`, `tx_data[7:0]`, `tx_busy`, `tx`;
  - internals: bit counter 0..9, baud counter 0..CLOCKS_PER_BIT-1, shift register.
- Top of block: FSM, address counter, byte register.

## Test plan

All scenarios use DEPTH=4, CLOCKS_PER_BIT=4 and a 1-cycle-latency memory model holding {0x00, 0xFF, 0x3C, 0x81}.

- Reset, no start for 100 cycles → `tx=1`, `busy=0`, `done=0`, `mem_addr=0` throughout.
- One-cycle `start` → UART decoder captures A5 5A 00 FF 3C 81.
  - `done` pulses once, (6·44) ± 2 cycles after start.
  - `busy` is high over exactly that window.
- Bit timing → every `tx` level change lies on a 4-cycle boundary relative to the first falling edge; each stop bit is high for 4 cycles.
- Reset low during the third byte → `tx=1` and `busy=0` the next cycle, no `done`.
  - A new `start` afterwards yields the full six-byte sequence again.
- `start` pulsed repeatedly during the dump, then held high across `done` → the first dump is unaltered.
  - A second dump begins immediately after `done`.
- DEPTH=1 → exactly A5 5A 00 is transmitted; `mem_addr` is only ever 0.
